// File: rtl/real2cpx_hilbert.sv
// real2cpx_hilbert
//   Converts a real signed sample stream into an analytic (complex) stream.
//   Re is the input delayed by the 7-sample group delay of the filter; Im is
//   the output of a 15-tap Hamming-windowed Hilbert FIR. One input sample is
//   taken every CADENCE clocks, and a single serial multiply-accumulate is
//   time-shared over the four non-zero coefficient pairs.
//
// Ports
//   clock  in   system clock, rising edge
//   reset  in   asynchronous reset, active low
//   IN     in   signed input sample, held stable for each sample period
//   EN     in   enable; sampling and output updates only while high
//   Re     out  signed real output (IN delayed by 7 samples, sign-extended)
//   Im     out  signed imaginary (Hilbert) output, rounded and saturated
module real2cpx_hilbert #(
    parameter int unsigned CADENCE = 20,
    parameter int unsigned IN_W    = 12,
    parameter int unsigned OUT_W   = 13
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  IN,
    input  logic                    EN,
    output logic signed [OUT_W-1:0] Re,
    output logic signed [OUT_W-1:0] Im
);

    localparam int unsigned TAPS  = 15;
    localparam int unsigned MID   = 7;
    localparam int unsigned PH_W  = $clog2(CADENCE);
    localparam int unsigned D_W   = IN_W + 1;   // pre-adder difference
    localparam int unsigned C_W   = 12;         // Q0.11 coefficient plus sign
    localparam int unsigned P_W   = D_W + C_W;
    localparam int unsigned ACC_W = P_W + 3;
    localparam int unsigned FRAC  = 11;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CADENCE - 1);
    // Output update lands 6 edges after capture; with CADENCE=6 that edge is
    // also the next capture edge, hence the modulo.
    localparam logic [PH_W-1:0] PH_UPD  = PH_W'(6 % CADENCE);

    localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1 << (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic {
        MAC_IDLE,
        MAC_RUN
    } mac_state_t;

    logic [PH_W-1:0]          ph_q, ph_d;
    logic signed [IN_W-1:0]   dl_q [TAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [1:0]               idx_q;
    mac_state_t               mac_q;
    logic                     res_vld_q;
    logic signed [OUT_W-1:0]  re_q, im_q;

    logic                     cap, upd;
    logic signed [IN_W-1:0]   tap_old, tap_new;
    logic signed [C_W-1:0]    coef;
    logic signed [D_W-1:0]    diff;
    logic signed [P_W-1:0]    prod;
    logic signed [ACC_W-1:0]  rnd_sum, im_full;
    logic signed [OUT_W-1:0]  im_sat;

    assign cap = EN && (ph_q == '0);
    assign upd = EN && (ph_q == PH_UPD) && res_vld_q;

    always_comb begin
        if (!EN)                  ph_d = '0;
        else if (ph_q == PH_LAST) ph_d = '0;
        else                      ph_d = ph_q + PH_W'(1);
    end

    // Pair m = 2*idx+1: c_m * (x[n-7-m] - x[n-7+m]); the antisymmetry lets
    // one multiply serve both taps of the pair.
    always_comb begin
        tap_old = dl_q[8];
        tap_new = dl_q[6];
        coef    = 12'sd1245;
        unique case (idx_q)
            2'd0: begin tap_old = dl_q[8];  tap_new = dl_q[6]; coef = 12'sd1245; end
            2'd1: begin tap_old = dl_q[10]; tap_new = dl_q[4]; coef = 12'sd279;  end
            2'd2: begin tap_old = dl_q[12]; tap_new = dl_q[2]; coef = 12'sd66;   end
            default: begin tap_old = dl_q[14]; tap_new = dl_q[0]; coef = 12'sd15; end
        endcase
        diff = D_W'(tap_old) - D_W'(tap_new);
        prod = P_W'(diff) * P_W'(coef);
        acc_d = acc_q + ACC_W'(prod);
    end

    // Round half toward +inf, then clamp to the output range.
    always_comb begin
        rnd_sum = acc_q + RND;
        im_full = rnd_sum >>> FRAC;
        if (im_full > SAT_HI)      im_sat = SAT_HI[OUT_W-1:0];
        else if (im_full < SAT_LO) im_sat = SAT_LO[OUT_W-1:0];
        else                       im_sat = im_full[OUT_W-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph_q      <= '0;
            for (int unsigned i = 0; i < TAPS; i++) dl_q[i] <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            mac_q     <= MAC_IDLE;
            res_vld_q <= 1'b0;
            re_q      <= '0;
            im_q      <= '0;
        end else begin
            ph_q <= ph_d;

            if (cap) begin
                dl_q[0] <= IN;
                for (int unsigned i = 1; i < TAPS; i++) dl_q[i] <= dl_q[i-1];
            end

            if (upd) begin
                re_q      <= OUT_W'(dl_q[MID]);
                im_q      <= im_sat;
                res_vld_q <= 1'b0;
            end

            // The MAC is not gated by EN: a sample already captured is always
            // fully accumulated even if EN drops mid-schedule.
            unique case (mac_q)
                MAC_IDLE: ;
                MAC_RUN: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        mac_q     <= MAC_IDLE;
                        res_vld_q <= 1'b1;
                    end
                end
            endcase

            if (cap) begin
                acc_q     <= '0;
                idx_q     <= '0;
                mac_q     <= MAC_RUN;
                res_vld_q <= 1'b0;
            end
        end
    end

    assign Re = re_q;
    assign Im = im_q;

endmodule

// File: tb/tb_real2cpx_hilbert.sv
module tb_real2cpx_hilbert;

    localparam int unsigned CAD = 20;

    logic               clock;
    logic               reset;
    logic signed [11:0] IN;
    logic               EN;
    logic signed [12:0] Re;
    logic signed [12:0] Im;

    real2cpx_hilbert #(
        .CADENCE(CAD),
        .IN_W   (12),
        .OUT_W  (13)
    ) dut (
        .clock(clock),
        .reset(reset),
        .IN   (IN),
        .EN   (EN),
        .Re   (Re),
        .Im   (Im)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int re;
        int im;
    } exp_t;

    exp_t sb[$];
    int   hist [15];
    int   coef_tab [4] = '{1245, 279, 66, 15};
    int   prev_re, prev_im;
    int   obs_im;
    int   errors = 0;
    int   checks = 0;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_im();
        int s, t, q;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            int m;
            m = 2 * i + 1;
            s += coef_tab[i] * (hist[7+m] - hist[7-m]);
        end
        t = s + 1024;
        q = t / 2048;
        if ((t % 2048 != 0) && (t < 0)) q = q - 1;   // floor division
        if (q > 4095)  q = 4095;
        if (q < -4096) q = -4096;
        return q;
    endfunction

    // Drives one sample starting just after an edge; the next edge captures.
    // Returns just after edge 19 of the sample period.
    task automatic send(input int v, input string tag, input bit has_exp,
                        input int er, input int ei);
        exp_t e;
        IN = 12'(v);
        EN = 1'b1;
        for (int i = 14; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
        if (has_exp) begin
            e.re = er;
            e.im = ei;
        end else begin
            e.re = hist[7];
            e.im = model_im();
        end
        sb.push_back(e);
        @(posedge clock);                      // capture edge
        repeat (5) @(posedge clock);
        #1;
        check_eq({tag, "_hold_re"}, Re, prev_re);
        check_eq({tag, "_hold_im"}, Im, prev_im);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check_eq({tag, "_re"}, Re, e.re);
        check_eq({tag, "_im"}, Im, e.im);
        obs_im  = Im;
        prev_re = e.re;
        prev_im = e.im;
        repeat (CAD - 7) @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 15; i++) hist[i] = 0;
        prev_re = 0;
        prev_im = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int imp_im [17] = '{-7, 0, -32, 0, -136, 0, -608, 0, 608, 0, 136, 0, 32, 0, 7, 0, 0};
        int tv [4]      = '{1000, 0, -1000, 0};
        int a;

        clear_model();
        reset = 1'b0;
        EN    = 1'b0;
        IN    = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_re", Re, 0);
        check_eq("rst_im", Im, 0);
        reset = 1'b1;

        // DC
        for (int k = 0; k < 20; k++) begin
            if (k >= 14) send(-500, "dc", 1'b1, -500, 0);
            else         send(-500, "dc", 1'b0, 0, 0);
        end

        // Reset mid-operation with non-zero history
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_eq("rst_mid_re", Re, 0);
        check_eq("rst_mid_im", Im, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        clear_model();

        // Impulse right after release: first EN edge must capture
        for (int k = 0; k < 17; k++)
            send((k == 0) ? 1000 : 0, "imp", 1'b1, (k == 7) ? 1000 : 0, imp_im[k]);

        // Extreme positive then negative
        for (int j = 14; j >= 0; j--) begin
            a = (j % 2 == 1) ? 0 : ((j >= 8) ? 2047 : -2048);
            if (j == 0) send(a, "ext_pos", 1'b1, 0, 3209);
            else        send(a, "ext_pos", 1'b0, 0, 0);
        end
        for (int j = 14; j >= 0; j--) begin
            a = (j % 2 == 1) ? 0 : ((j >= 8) ? -2048 : 2047);
            if (j == 0) send(a, "ext_neg", 1'b1, 0, -3209);
            else        send(a, "ext_neg", 1'b0, 0, 0);
        end

        // fs/4 tone, with an EN drop in the middle
        for (int k = 0; k < 32; k++) begin
            if (k == 12) begin
                EN = 1'b0;
                repeat (18) @(posedge clock);
                #1;
                check_eq("en_mid_re", Re, prev_re);
                check_eq("en_mid_im", Im, prev_im);
                repeat (19) @(posedge clock);
                #1;
                check_eq("en_end_re", Re, prev_re);
                check_eq("en_end_im", Im, prev_im);
            end
            send(tv[k % 4], "tone", 1'b0, 0, 0);
            if (k >= 16 && (k % 2 == 0)) begin
                a = (obs_im < 0) ? -obs_im : obs_im;
                check_eq("tone_mag", (a >= 990 && a <= 1010) ? 1 : 0, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/real2cpx_hilbert.md
Name: real2cpx_hilbert

Overview:
- Converts a real 12-bit sample stream into a complex (analytic) 13-bit stream.
- Re is the input delayed by the filter group delay.
- Im is the output of a 15-tap Hamming-windowed Hilbert FIR.
- Samples arrive once every CADENCE clocks; a single serial multiplier-accumulator is time-shared over that period. The block sits between the ADC sample front-end and the complex downconversion/demod chain.

Parameters:
- CADENCE, 20, clocks per input sample (minimum 6).
- IN_W, 12, input width (signed).
- OUT_W, 13, output width (signed).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous reset, active-low (asserted at 0).
- IN  in  12  signed two's-complement input sample; held stable for each sample period.
- EN  in  1  enable; sampling and processing run only while 1.
- Re  out  13  signed real output.
- Im  out  13  signed imaginary (Hilbert) output.

Behaviour:
- Reset (reset=0, async): delay line, accumulator, phase counter, Re and Im all cleared to 0; MAC idle.
- Phase counter 0..CADENCE-1 increments each clock while EN=1 and wraps to 0. While EN=0 it is forced to 0, the MAC finishes any pending accumulation, and the delay line and outputs hold.
- Capture: on a rising edge with EN=1 and counter=0, IN is shifted into a 15-deep delay line, x[n]..x[n-14]. The first capture therefore occurs on the first EN-high edge, then every CADENCE clocks.
- Coefficients, Q0.11 integers (×2^-11), antisymmetric; even taps are zero: c1=1245, c3=279, c5=66, c7=15.
- Im[n] = round( Σ over m∈{1,3,5,7} of c_m·(x[n-7-m] − x[n-7+m]) / 2048 ).
- Serial MAC schedule, one pair per clock on the 4 clocks after capture:
  - Pre-add forms a 13-bit difference.
  - Multiply by the 11-bit coefficient.
  - Accumulate in a signed accumulator of at least 26 bits, cleared at capture.
- Rounding: add 1024, then arithmetic shift right by 11 (round half toward +inf).
- Saturate to [−4096, 4095]. Saturation is unreachable with these coefficients but is required as a guard.
- Re[n] = x[n−7], sign-extended to 13 bits (group-delay matched).
- Update timing: Re and Im update together, once per sample, on the 6th rising edge after the capture edge (capture edge = edge 0). They hold between updates.
- Latency in samples: an impulse entering at sample n0 appears on Re at sample n0+7. Im is nonzero at samples n0, n0+2, n0+4, n0+6, n0+8, n0+10, n0+12 and n0+14.
- Reset mid-operation: everything clears at once. After release, the first EN-high edge is a capture edge.

Test Plan:
- Reset: drive reset=0 with nonzero history, then release → Re=Im=0; first EN edge captures the sample; outputs update 6 clocks later.
- Impulse of IN=1000 at n0, 0 elsewhere, CADENCE=20 → per-sample Im:
  - n0: −7; n0+2: −32; n0+4: −136; n0+6: −608; n0+8: +608; n0+10: +136; n0+12: +32; n0+14: +7; all others 0.
  - Re = 1000 only at n0+7.
- DC input IN=−500 held for 20 samples → from sample 14 onward Re=−500 and Im=0.
- Extreme case: delay line set so that x[n−8,−10,−12,−14]=2047 and x[n−6,−4,−2,n]=−2048 → Im=3209, no wrap.
  - With the signs of the extreme pattern swapped → Im=−3209.
- EN gating: drop EN for 37 clocks mid-stream → outputs and delay line hold. After EN returns, the first EN edge captures, then every 20 clocks; sequence is identical to an uninterrupted run.
- Tone at fs/4 (IN = 1000, 0, −1000, 0, ...) → after settling, Im sequence lags Re by 90° with magnitude within 1% of |Re| (about 1000).
